barrel_shifter: RTL and testbench
=================================

BARREL_SHIFTER -- requirements
Module: barrel_shifter

Interface
REQ-001 SHALL have parameter p_DATA_WIDTH, default 8, word width; power of two, >= 2.
REQ-002 SHALL have local parameter lp_SFT_AMT_WIDTH = $clog2(p_DATA_WIDTH), shift-amount width and pipeline depth.
REQ-003 SHALL have port i_CLK  input  1  clock; all state on rising edge.
REQ-004 SHALL have port i_RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_VALID  input  1  input word present.
REQ-006 SHALL have port o_READY  output  1  block accepts input this cycle.
REQ-007 SHALL have port i_INPUT  input  p_DATA_WIDTH  word to shift.
REQ-008 SHALL have port i_SHIFT_AMOUNT  input  lp_SFT_AMT_WIDTH  shift distance, 0..p_DATA_WIDTH-1.
REQ-009 SHALL have port i_MODE  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-010 SHALL have port o_VALID  output  1  o_RESULT valid.
REQ-011 SHALL have port i_READY  input  1  downstream accepts o_RESULT.
REQ-012 SHALL have port o_RESULT  output  p_DATA_WIDTH  shifted word.

Function
REQ-013 SHALL implement lp_SFT_AMT_WIDTH registered stages; stage k shifts by 2^k when amount bit k set, else passes through.
REQ-014 SHALL carry mode, remaining amount bits and a valid bit alongside data in every stage.
REQ-015 SHALL produce o_RESULT exactly lp_SFT_AMT_WIDTH cycles after acceptance when unstalled.
REQ-016 SHALL accept input on a cycle where i_VALID && o_READY.
REQ-017 SHALL drive o_READY = !o_VALID || i_READY; the whole pipeline advances only when o_READY is high.
REQ-018 SHALL hold all stages, o_VALID and o_RESULT stable while o_VALID && !i_READY.
REQ-019 SHALL sustain one word per cycle with i_READY constantly high.
REQ-020 SHALL insert a bubble (valid 0) into stage 0 when advancing without acceptance.
REQ-021 SHALL zero-fill vacated bits for SLL/SRL; SRA SHALL fill with the input MSB.
REQ-022 SHALL return the input unchanged for shift amount 0 in every mode.
REQ-023 SHALL keep o_RESULT at its last value when o_VALID is low.

Reset
REQ-024 SHALL clear o_VALID, all stage valid bits, o_RESULT and all stage data to 0 asynchronously on i_RST.
REQ-025 SHALL discard in-flight words on reset mid-operation; no output appears from them after release.
REQ-026 SHALL drive o_READY high during and after reset (no output pending).

Configuration
REQ-027 SHALL compile rotate support under macro BARREL_SHIFTER_ROTATE_EN.
REQ-028 With BARREL_SHIFTER_ROTATE_EN defined, mode 11 SHALL rotate left, MSBs wrapping into LSBs.
REQ-029 Without it, mode 11 SHALL behave as SLL and no rotate logic SHALL be synthesised.

Structure
REQ-030 SHALL take mode encodings (SLL, SRL, SRA, ROL) from shared package shifter_pkg.
REQ-031 SHALL instantiate sub-module shift_stage (parameters: width, stage distance) once per stage via generate.

Verification
REQ-032 SLL, 0x81, amount 1, i_READY high -> 0x02 with o_VALID exactly 3 cycles after acceptance.
REQ-033 SRA 0x80 amount 3 -> 0xF0; SRL 0x80 amount 7 -> 0x01; any mode amount 0 on 0xA5 -> 0xA5.
REQ-034 ROL 0x81 amount 1 -> 0x03 with macro; -> 0x02 without macro.
REQ-035 Back-to-back words 0x01..0x08 SLL 1, i_READY low 4 cycles mid-stream -> o_RESULT held, o_READY low, all eight results 0x02..0x10 in order, none lost or duplicated.
REQ-036 i_RST pulsed with 2 words in flight -> o_VALID 0, o_RESULT 0 immediately; no stale output after release.
REQ-037 Random stimulus over all modes/amounts -> every o_RESULT matches a reference model shift of the accepted word.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared definitions for the barrel shifter pipeline: shift mode encodings.
package shifter_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROL = 2'b11
    } shift_mode_e;

endpackage

// File: rtl/shift_stage.sv
// One registered barrel-shifter stage: shifts by p_DIST when its amount bit is set.
// Rotate support is compiled in only when BARREL_SHIFTER_ROTATE_EN is defined.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int p_DATA_WIDTH = 8,
    parameter int p_DIST       = 1,
    localparam int lp_AMT_WIDTH = $clog2(p_DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    advance,
    input  logic                    prev_valid,
    input  logic [p_DATA_WIDTH-1:0] prev_data,
    input  logic [1:0]              prev_mode,
    input  logic [lp_AMT_WIDTH-1:0] prev_amt,
    output logic                    valid,
    output logic [p_DATA_WIDTH-1:0] data,
    output logic [1:0]              mode,
    output logic [lp_AMT_WIDTH-1:0] amt
);

    localparam int lp_BIT = $clog2(p_DIST);

    logic [p_DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted = prev_data;
        if (prev_amt[lp_BIT]) begin
            case (prev_mode)
                MODE_SRL: shifted = prev_data >> p_DIST;
                MODE_SRA: shifted = $signed(prev_data) >>> p_DIST;
`ifdef BARREL_SHIFTER_ROTATE_EN
                MODE_ROL: shifted = (prev_data << p_DIST) | (prev_data >> (p_DATA_WIDTH - p_DIST));
`endif
                default:  shifted = prev_data << p_DIST;
            endcase
        end
    end

    // Bubbles leave data untouched so the output holds its last valid word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            mode  <= '0;
            amt   <= '0;
        end else if (advance) begin
            valid <= prev_valid;
            mode  <= prev_mode;
            amt   <= prev_amt;
            if (prev_valid) begin
                data <= shifted;
            end
        end
    end

endmodule

// File: rtl/barrel_shifter.sv
// Pipelined logarithmic barrel shifter with valid/ready handshake, one stage per amount bit.
// Mode 11 rotates left only when BARREL_SHIFTER_ROTATE_EN is defined, otherwise acts as SLL.
module barrel_shifter #(
    parameter int p_DATA_WIDTH = 8,
    localparam int lp_SFT_AMT_WIDTH = $clog2(p_DATA_WIDTH)
) (
    input  logic                        i_CLK,
    input  logic                        i_RST,
    input  logic                        i_VALID,
    output logic                        o_READY,
    input  logic [p_DATA_WIDTH-1:0]     i_INPUT,
    input  logic [lp_SFT_AMT_WIDTH-1:0] i_SHIFT_AMOUNT,
    input  logic [1:0]                  i_MODE,
    output logic                        o_VALID,
    input  logic                        i_READY,
    output logic [p_DATA_WIDTH-1:0]     o_RESULT
);

    localparam int lp_N = lp_SFT_AMT_WIDTH;

    logic                        valid_s [0:lp_N];
    logic [p_DATA_WIDTH-1:0]     data_s  [0:lp_N];
    logic [1:0]                  mode_s  [0:lp_N];
    logic [lp_SFT_AMT_WIDTH-1:0] amt_s   [0:lp_N];
    logic                        advance;
    logic                        unused_tail;

    assign valid_s[0] = i_VALID;
    assign data_s[0]  = i_INPUT;
    assign mode_s[0]  = i_MODE;
    assign amt_s[0]   = i_SHIFT_AMOUNT;

    // The whole pipeline moves as one; a held output freezes every stage.
    assign o_READY = !o_VALID || i_READY;
    assign advance = o_READY;

    for (genvar k = 0; k < lp_N; k++) begin : g_stage
        shift_stage #(
            .p_DATA_WIDTH(p_DATA_WIDTH),
            .p_DIST      (1 << k)
        ) u_stage (
            .clk       (i_CLK),
            .rst       (i_RST),
            .advance   (advance),
            .prev_valid(valid_s[k]),
            .prev_data (data_s[k]),
            .prev_mode (mode_s[k]),
            .prev_amt  (amt_s[k]),
            .valid     (valid_s[k+1]),
            .data      (data_s[k+1]),
            .mode      (mode_s[k+1]),
            .amt       (amt_s[k+1])
        );
    end

    assign o_VALID  = valid_s[lp_N];
    assign o_RESULT = data_s[lp_N];

    assign unused_tail = ^{mode_s[lp_N], amt_s[lp_N]};

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter: directed table, stall/reset sequences, random vs. model.
module tb_barrel_shifter;
    import shifter_pkg::*;

    localparam int W  = 8;
    localparam int AW = 3;

    logic          i_CLK = 1'b0;
    logic          i_RST;
    logic          i_VALID;
    logic          o_READY;
    logic [W-1:0]  i_INPUT;
    logic [AW-1:0] i_SHIFT_AMOUNT;
    logic [1:0]    i_MODE;
    logic          o_VALID;
    logic          i_READY;
    logic [W-1:0]  o_RESULT;

    int vectors     = 0;
    int miscompares = 0;
    int rx_cnt      = 0;
    logic [W-1:0] exp_q [$];

    typedef struct {
        logic [W-1:0]  data;
        logic [AW-1:0] amt;
        logic [1:0]    mode;
        logic [W-1:0]  expect_val;
    } vec_t;

    vec_t tbl [$];

    barrel_shifter #(.p_DATA_WIDTH(W)) dut (
        .i_CLK         (i_CLK),
        .i_RST         (i_RST),
        .i_VALID       (i_VALID),
        .o_READY       (o_READY),
        .i_INPUT       (i_INPUT),
        .i_SHIFT_AMOUNT(i_SHIFT_AMOUNT),
        .i_MODE        (i_MODE),
        .o_VALID       (o_VALID),
        .i_READY       (i_READY),
        .o_RESULT      (o_RESULT)
    );

    always #5 i_CLK = ~i_CLK;

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int a, input logic [1:0] m);
        int v;
        case (m)
            2'b01:   v = int'(d) >> a;
            2'b10:   v = (int'(d) - (d[W-1] ? 256 : 0)) >>> a;
`ifdef BARREL_SHIFTER_ROTATE_EN
            2'b11:   v = (int'(d) << a) | (int'(d) >> (W - a));
`endif
            default: v = int'(d) << a;
        endcase
        return v[W-1:0];
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // Outputs are consumed on edges where o_VALID && i_READY; check them mid-cycle.
    always @(negedge i_CLK) begin
        if (!i_RST && o_VALID && i_READY) begin
            rx_cnt++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: got 0x%02h, expected no output", o_RESULT);
            end else begin
                check("result", o_RESULT, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [AW-1:0] a, input logic [1:0] m,
                        input logic [W-1:0] exp, input bit push);
        int guard;
        i_VALID        = 1'b1;
        i_INPUT        = d;
        i_SHIFT_AMOUNT = a;
        i_MODE         = m;
        guard          = 0;
        forever begin
            @(negedge i_CLK);
            if (o_READY) break;
            guard++;
            if (guard > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: got o_READY=0, expected 1 within 200 cycles");
                break;
            end
        end
        @(posedge i_CLK);
        #1;
        if (push) exp_q.push_back(exp);
    endtask

    task automatic drain();
        int guard;
        i_VALID = 1'b0;
        i_READY = 1'b1;
        guard   = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge i_CLK);
            guard++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge i_CLK);
        #1;
    endtask

    initial begin
        logic [W-1:0] held;
        logic [W-1:0] rd;
        logic [AW-1:0] ra;
        logic [1:0] rm;
        int rx_before;
        bit done;

        i_RST = 1'b1;
        i_VALID = 1'b0;
        i_READY = 1'b1;
        i_INPUT = '0;
        i_SHIFT_AMOUNT = '0;
        i_MODE = 2'b00;

        tbl.push_back('{8'h81, 3'd1, MODE_SLL, 8'h02});
        tbl.push_back('{8'h80, 3'd3, MODE_SRA, 8'hF0});
        tbl.push_back('{8'h80, 3'd7, MODE_SRL, 8'h01});
        tbl.push_back('{8'hA5, 3'd0, MODE_SLL, 8'hA5});
        tbl.push_back('{8'hA5, 3'd0, MODE_SRL, 8'hA5});
        tbl.push_back('{8'hA5, 3'd0, MODE_SRA, 8'hA5});
        tbl.push_back('{8'hA5, 3'd0, MODE_ROL, 8'hA5});
        tbl.push_back('{8'hFF, 3'd7, MODE_SLL, 8'h80});
        tbl.push_back('{8'h7F, 3'd7, MODE_SRA, 8'h00});
        tbl.push_back('{8'hFF, 3'd4, MODE_SRL, 8'h0F});
        tbl.push_back('{8'h96, 3'd2, MODE_SRA, 8'hE5});
`ifdef BARREL_SHIFTER_ROTATE_EN
        tbl.push_back('{8'h81, 3'd1, MODE_ROL, 8'h03});
        tbl.push_back('{8'hF0, 3'd4, MODE_ROL, 8'h0F});
`else
        tbl.push_back('{8'h81, 3'd1, MODE_ROL, 8'h02});
        tbl.push_back('{8'hF0, 3'd4, MODE_ROL, 8'h00});
`endif

        repeat (2) @(posedge i_CLK);
        #1;
        check("reset_valid", {7'd0, o_VALID}, 8'd0);
        check("reset_result", o_RESULT, 8'd0);
        check("reset_ready", {7'd0, o_READY}, 8'd1);
        i_RST = 1'b0;
        @(posedge i_CLK);
        #1;

        // Latency: acceptance edge counts as the first of three.
        send(8'h81, 3'd1, MODE_SLL, 8'h02, 1'b1);
        i_VALID = 1'b0;
        check("lat_edge1_valid", {7'd0, o_VALID}, 8'd0);
        @(posedge i_CLK);
        #1;
        check("lat_edge2_valid", {7'd0, o_VALID}, 8'd0);
        @(posedge i_CLK);
        #1;
        check("lat_edge3_valid", {7'd0, o_VALID}, 8'd1);
        check("lat_edge3_result", o_RESULT, 8'h02);
        drain();

        foreach (tbl[i]) send(tbl[i].data, tbl[i].amt, tbl[i].mode, tbl[i].expect_val, 1'b1);
        drain();
        check("hold_after_drain_valid", {7'd0, o_VALID}, 8'd0);
        check("hold_after_drain_result", o_RESULT, tbl[tbl.size()-1].expect_val);

        // Back-to-back stream with a four-cycle downstream stall.
        rx_before = rx_cnt;
        fork
            begin
                for (int i = 1; i <= 8; i++) send(W'(i), 3'd1, MODE_SLL, W'(i << 1), 1'b1);
                i_VALID = 1'b0;
            end
            begin
                repeat (4) @(posedge i_CLK);
                #2;
                i_READY = 1'b0;
                held = o_RESULT;
                check("stall_valid", {7'd0, o_VALID}, 8'd1);
                repeat (4) begin
                    @(negedge i_CLK);
                    check("stall_ready", {7'd0, o_READY}, 8'd0);
                    check("stall_result_held", o_RESULT, held);
                end
                @(posedge i_CLK);
                #2;
                i_READY = 1'b1;
            end
        join
        drain();
        check("stream_count", W'(rx_cnt - rx_before), 8'd8);

        // Reset with two words in flight, one of them parked at the output.
        i_READY = 1'b0;
        send(8'h11, 3'd1, MODE_SLL, 8'h00, 1'b0);
        send(8'h22, 3'd2, MODE_SRL, 8'h00, 1'b0);
        i_VALID = 1'b0;
        repeat (3) @(posedge i_CLK);
        #2;
        check("rst_pre_valid", {7'd0, o_VALID}, 8'd1);
        i_RST = 1'b1;
        #1;
        check("rst_valid", {7'd0, o_VALID}, 8'd0);
        check("rst_result", o_RESULT, 8'd0);
        check("rst_ready", {7'd0, o_READY}, 8'd1);
        @(negedge i_CLK);
        i_RST = 1'b0;
        i_READY = 1'b1;
        rx_before = rx_cnt;
        repeat (8) @(posedge i_CLK);
        #1;
        check("post_rst_valid", {7'd0, o_VALID}, 8'd0);
        check("post_rst_no_output", W'(rx_cnt - rx_before), 8'd0);

        // Random words, random gaps and random downstream back-pressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        i_VALID = 1'b0;
                        @(posedge i_CLK);
                        #1;
                    end
                    rd = W'($urandom);
                    ra = AW'($urandom_range(0, 7));
                    rm = 2'($urandom_range(0, 3));
                    send(rd, ra, rm, model(rd, int'(ra), rm), 1'b1);
                end
                i_VALID = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge i_CLK);
                    #1;
                    i_READY = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
